hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Stall/flush controller paired with the forwarding logic in the 5-stage RISC-V pipeline.
//  It handles the hazards forwarding cannot resolve:
//   - load-use: inserts a bubble.
//   - taken branch resolved in EX: flushes IF/ID and ID/EX.
//   - slow data memory: freezes the pipe with a valid/ready wait FSM and a timeout.
//  Saturating performance counters record stall cycles and flush events.
// PARAMETERS
//  MAX_WAIT  16  MEM_WAIT cycles tolerated before mem_timeout is raised (>=1)
//  CNT_W     16  width of each performance counter
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      asynchronous reset, active-low
//  Id_RegRs1      in   5      rs1 of the instruction in ID
//  Id_RegRs2      in   5      rs2 of the instruction in ID
//  Id_useRs1      in   1      ID instruction reads rs1
//  Id_useRs2      in   1      ID instruction reads rs2
//  Ex_memRead     in   1      EX instruction is a load
//  Ex_RegRd       in   5      rd of the EX instruction
//  Ex_branchTaken in   1      EX branch/jump resolved taken
//  Mem_memAccess  in   1      MEM instruction issues a dmem read or write
//  dmem_ready     in   1      data memory completes the access this cycle
//  cnt_clr        in   1      synchronous clear of both counters
//  pc_write       out  1      PC register enable
//  ifid_write     out  1      IF/ID register enable
//  ifid_flush     out  1      IF/ID loads a NOP
//  idex_bubble    out  1      ID/EX loads control zeros (NOP)
//  pipe_hold      out  1      ID/EX, EX/MEM and MEM/WB hold their contents
//  mem_timeout    out  1      sticky: a MEM_WAIT exceeded MAX_WAIT cycles
//  stall_cycles   out  CNT_W  cycles with pc_write==0
//  flush_events   out  CNT_W  taken-branch flushes
// BEHAVIOUR
//  Reset (rst_i=0)
//   - State=RUN; counters=0; mem_timeout=0; wait_cnt=0.
//   - All combinational outputs=0 while reset is asserted (pc_write=0).
//  Outputs are Mealy: derived from state plus current inputs, no added latency.
//  Defaults: pc_write=1, ifid_write=1, all others 0.
//  Evaluation order, first match wins:
//   1. mem_wait = Mem_memAccess & ~dmem_ready.
//      pc_write=0, ifid_write=0, pipe_hold=1. Next state MEM_WAIT.
//      A branch or load-use present this cycle is deferred. Its inputs stay frozen and it is re-evaluated on release.
//   2. Ex_branchTaken: ifid_flush=1, idex_bubble=1. PC still writes the target. flush_events+1.
//   3. load_use = Ex_memRead & Ex_RegRd!=0 & ((Id_useRs1 & Ex_RegRd==Id_RegRs1) | (Id_useRs2 & Ex_RegRd==Id_RegRs2)).
//      Response: pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble, since the load then moves to MEM.
//  MEM_WAIT state
//   - Freeze outputs (rule 1) while dmem_ready=0.
//   - wait_cnt: cleared on entry; +1 per cycle.
//   - When wait_cnt==MAX_WAIT with ready still 0: mem_timeout<=1 (sticky until reset) and the freeze continues.
//   - On dmem_ready=1: freeze drops that same cycle, rules 2-3 apply, and next state is RUN.
//  Counters
//   - stall_cycles +1 on every post-reset cycle with pc_write=0.
//   - Both counters saturate at all-ones.
//   - cnt_clr has priority over an increment in the same cycle.
//  Simultaneous events
//   - Branch + load-use in one cycle: the flush wins. The ID instruction is squashed anyway, so no stall is counted.
//  Reset mid-wait returns to RUN immediately; counters and mem_timeout clear.
// TESTING
//  1. lw x5 in EX, ID add x6,x5,x1 (Id_useRs1=1) -> one cycle of pc_write=0/idex_bubble=1, then normal; stall_cycles=1.
//  2. Ex_memRead=1, Ex_RegRd=0, Id_RegRs1=0 -> no stall; pc_write=1.
//  3. Ex_branchTaken=1 -> ifid_flush=1, idex_bubble=1, pc_write=1; flush_events=1.
//  4. Ex_branchTaken=1 together with a load-use match -> flush only; stall_cycles unchanged.
//  5. Mem_memAccess=1 with dmem_ready low 3 cycles, then high -> pipe_hold=1 for 3 cycles, released in cycle 4; stall_cycles=3.
//  6. MAX_WAIT=4, ready held low 10 cycles -> mem_timeout rises after the 5th wait cycle and stays high.
//     Then assert rst_i=0 -> mem_timeout=0, state RUN, counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage RISC-V pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait freeze with timeout, and perf counters.
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       Id_RegRs1,
    input  logic [4:0]       Id_RegRs2,
    input  logic             Id_useRs1,
    input  logic             Id_useRs2,
    input  logic             Ex_memRead,
    input  logic [4:0]       Ex_RegRd,
    input  logic             Ex_branchTaken,
    input  logic             Mem_memAccess,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_events_q, flush_events_d;

    logic load_use;
    logic freeze;
    logic branch_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(MAX_WAIT)) ? v : v + WAIT_W'(1);
    endfunction

    // Hazard detection: x0 never creates a dependency.
    always_comb begin
        load_use = Ex_memRead && (Ex_RegRd != 5'd0) &&
                   ((Id_useRs1 && (Ex_RegRd == Id_RegRs1)) ||
                    (Id_useRs2 && (Ex_RegRd == Id_RegRs2)));
    end

    // Once waiting, only dmem_ready releases the freeze.
    always_comb begin
        if (state_q == ST_MEM_WAIT) begin
            freeze = ~dmem_ready;
        end else begin
            freeze = Mem_memAccess & ~dmem_ready;
        end
    end

    // Mealy outputs; a freeze defers any branch or load-use until release.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        branch_fire = 1'b0;
        if (!rst_i) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (Ex_branchTaken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            branch_fire = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Next state and wait tracking; wait_cnt reaches MAX_WAIT on the
    // (MAX_WAIT+1)th consecutive frozen cycle.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (freeze) begin
                    wait_cnt_d = wait_inc(wait_cnt_q);
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (freeze && (wait_cnt_q == WAIT_W'(MAX_WAIT))) begin
            mem_timeout_d = 1'b1;
        end
    end

    // Performance counters: clear beats increment, both saturate.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (cnt_clr) begin
            stall_cycles_d = '0;
            flush_events_d = '0;
        end else begin
            if (!pc_write) begin
                stall_cycles_d = sat_inc(stall_cycles_q);
            end
            if (branch_fire) begin
                flush_events_d = sat_inc(flush_events_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed hazard scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       Id_RegRs1, Id_RegRs2, Ex_RegRd;
    logic             Id_useRs1, Id_useRs2, Ex_memRead, Ex_branchTaken;
    logic             Mem_memAccess, dmem_ready, cnt_clr;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_wait  = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_tmo   = 0;

    always #5 clk_i = ~clk_i;

    hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .Id_RegRs1(Id_RegRs1), .Id_RegRs2(Id_RegRs2),
        .Id_useRs1(Id_useRs1), .Id_useRs2(Id_useRs2),
        .Ex_memRead(Ex_memRead), .Ex_RegRd(Ex_RegRd),
        .Ex_branchTaken(Ex_branchTaken), .Mem_memAccess(Mem_memAccess),
        .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        Id_RegRs1 = 5'd0; Id_RegRs2 = 5'd0; Id_useRs1 = 1'b0; Id_useRs2 = 1'b0;
        Ex_memRead = 1'b0; Ex_RegRd = 5'd0; Ex_branchTaken = 1'b0;
        Mem_memAccess = 1'b0; dmem_ready = 1'b1; cnt_clr = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied: checks this
    // cycle's outputs, then advances the model across the next rising edge.
    task automatic cyc(input string tag);
        bit mw, lu;
        int e_pc, e_ifw, e_fl, e_bub, e_hold;
        #1;
        if (!rst_i) begin
            m_wait = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
            check_eq({tag, ".rst_pc"}, 32'(pc_write), 0);
            check_eq({tag, ".rst_ifw"}, 32'(ifid_write), 0);
            check_eq({tag, ".rst_flush"}, 32'(ifid_flush), 0);
            check_eq({tag, ".rst_bub"}, 32'(idex_bubble), 0);
            check_eq({tag, ".rst_hold"}, 32'(pipe_hold), 0);
            check_eq({tag, ".rst_tmo"}, 32'(mem_timeout), 0);
            check_eq({tag, ".rst_stall"}, 32'(stall_cycles), 0);
            check_eq({tag, ".rst_fcnt"}, 32'(flush_events), 0);
            return;
        end
        mw = Mem_memAccess && !dmem_ready;
        lu = Ex_memRead && (Ex_RegRd != 0) &&
             ((Id_useRs1 && Ex_RegRd == Id_RegRs1) || (Id_useRs2 && Ex_RegRd == Id_RegRs2));
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0;
        if (mw) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
        end else if (Ex_branchTaken) begin
            e_fl = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end
        check_eq({tag, ".pc_write"}, 32'(pc_write), 32'(e_pc));
        check_eq({tag, ".ifid_write"}, 32'(ifid_write), 32'(e_ifw));
        check_eq({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_fl));
        check_eq({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        check_eq({tag, ".pipe_hold"}, 32'(pipe_hold), 32'(e_hold));
        check_eq({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_tmo));
        check_eq({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        check_eq({tag, ".flush_events"}, 32'(flush_events), 32'(m_flush));
        if (mw) begin
            m_wait++;
            if (m_wait > MAX_WAIT) m_tmo = 1;
        end else begin
            m_wait = 0;
        end
        if (cnt_clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (e_pc == 0) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
            if (e_fl == 1) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        end
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        Ex_memRead = 1'b1; Ex_RegRd = rd; Id_RegRs1 = rd; Id_useRs1 = 1'b1;
        Id_RegRs2 = 5'd1; Id_useRs2 = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b0;
        // reset: outputs forced low even with a branch pending
        @(negedge clk_i); Ex_branchTaken = 1'b1; cyc("reset0");
        @(negedge clk_i); cyc("reset1");
        @(negedge clk_i); rst_i = 1'b1; idle_inputs(); cyc("idle");

        // 1: lw x5 / add x6,x5,x1
        @(negedge clk_i); idle_inputs(); set_load_use(5'd5); cyc("t1_lu");
        check_eq("t1_lu_pc", 32'(pc_write), 0);
        @(negedge clk_i); idle_inputs(); Mem_memAccess = 1'b1; cyc("t1_after");
        check_eq("t1_after_pc", 32'(pc_write), 1);
        @(negedge clk_i); idle_inputs(); cyc("t1_idle");
        check_eq("t1_stall_cnt", 32'(stall_cycles), 1);

        // 2: load to x0 never stalls
        @(negedge clk_i); idle_inputs(); Ex_memRead = 1'b1; Id_useRs1 = 1'b1; cyc("t2_x0");
        check_eq("t2_pc", 32'(pc_write), 1);

        // 3: taken branch
        @(negedge clk_i); idle_inputs(); Ex_branchTaken = 1'b1; cyc("t3_br");
        @(negedge clk_i); idle_inputs(); cyc("t3_idle");
        check_eq("t3_flush_cnt", 32'(flush_events), 1);

        // 4: branch and load-use together
        @(negedge clk_i); idle_inputs(); set_load_use(5'd7); Ex_branchTaken = 1'b1; cyc("t4_both");
        check_eq("t4_pc", 32'(pc_write), 1);
        @(negedge clk_i); idle_inputs(); cyc("t4_idle");
        check_eq("t4_stall_cnt", 32'(stall_cycles), 1);
        check_eq("t4_flush_cnt", 32'(flush_events), 2);

        // 5: three-cycle memory wait
        @(negedge clk_i); idle_inputs(); cnt_clr = 1'b1; cyc("t5_clr");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); idle_inputs(); Mem_memAccess = 1'b1; dmem_ready = 1'b0; cyc("t5_wait");
            check_eq("t5_hold", 32'(pipe_hold), 1);
        end
        @(negedge clk_i); idle_inputs(); Mem_memAccess = 1'b1; cyc("t5_release");
        check_eq("t5_released", 32'(pipe_hold), 0);
        @(negedge clk_i); idle_inputs(); cyc("t5_idle");
        check_eq("t5_stall_cnt", 32'(stall_cycles), 3);

        // 6: timeout, then reset mid-wait
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i); idle_inputs(); Mem_memAccess = 1'b1; dmem_ready = 1'b0; cyc("t6_wait");
            check_eq("t6_tmo", 32'(mem_timeout), (i > 5) ? 1 : 0);
        end
        @(negedge clk_i); rst_i = 1'b0; cyc("t6_rst");
        check_eq("t6_rst_tmo", 32'(mem_timeout), 0);
        // back in RUN: no access pending and ready low must not freeze
        @(negedge clk_i); rst_i = 1'b1; idle_inputs(); dmem_ready = 1'b0; cyc("t6_run");
        check_eq("t6_run_hold", 32'(pipe_hold), 0);

        // saturation and clear-over-increment
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i); idle_inputs(); set_load_use(5'd3); cyc("sat_stall");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i); idle_inputs(); Ex_branchTaken = 1'b1; cyc("sat_flush");
        end
        check_eq("sat_stall_cnt", 32'(stall_cycles), CNT_MAX);
        @(negedge clk_i); idle_inputs(); set_load_use(5'd3); cnt_clr = 1'b1; cyc("clr_prio");
        @(negedge clk_i); idle_inputs(); cyc("clr_idle");
        check_eq("clr_prio_cnt", 32'(stall_cycles), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            rst_i          = ($urandom_range(0, 299) != 0);
            Id_RegRs1      = 5'($urandom_range(0, 3));
            Id_RegRs2      = 5'($urandom_range(0, 3));
            Id_useRs1      = 1'($urandom_range(0, 1));
            Id_useRs2      = 1'($urandom_range(0, 1));
            Ex_memRead     = 1'($urandom_range(0, 1));
            Ex_RegRd       = 5'($urandom_range(0, 3));
            Ex_branchTaken = ($urandom_range(0, 3) == 0);
            Mem_memAccess  = (m_wait > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            dmem_ready     = ($urandom_range(0, 2) == 0) ? 1'b0 : ((m_wait > 0) ? 1'($urandom_range(0, 1)) : 1'b1);
            cnt_clr        = ($urandom_range(0, 99) == 0);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
